// File: rtl/histogram_integrator.sv
// ============================================================================
// Module      : histogram_integrator
// Description : Rebuilds histogram bins from a base value plus a stream of
//               first differences, one bin per accepted beat.
//               Optional running-sum output enabled by HIST_INTEG_CDF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module histogram_integrator #(
    parameter int BINS  = 256,
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_base,
    input  logic [WIDTH-1:0] i_deriv,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [IDX_W-1:0] o_bin,
    output logic             o_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
`ifdef HIST_INTEG_CDF_EN
    output logic [WIDTH+IDX_W-1:0] o_cdf,
`endif
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_BIN = IDX_W'(BINS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [IDX_W-1:0] bin_q,   bin_d;
    logic             last_q,  last_d;
    logic             done_q,  done_d;
    logic             w_accept;

`ifdef HIST_INTEG_CDF_EN
    logic [WIDTH+IDX_W-1:0] cdf_q, cdf_d;
`endif

    assign o_ready  = (state_q == S_RUN) && (!valid_q || i_ready);
    assign w_accept = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        bin_d   = bin_q;
        last_d  = last_q;
        done_d  = 1'b0;
`ifdef HIST_INTEG_CDF_EN
        cdf_d   = cdf_q;
`endif

        // A drain frees the output slot; an accept in the same cycle refills it.
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    acc_d   = i_base;
                    idx_d   = '0;
                    state_d = S_RUN;
`ifdef HIST_INTEG_CDF_EN
                    cdf_d   = '0;
`endif
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    // Bin 0 carries the base; its derivative sample is discarded.
                    data_d  = (idx_q == '0) ? acc_q : (acc_q + i_deriv);
                    acc_d   = data_d;
                    valid_d = 1'b1;
                    bin_d   = idx_q;
                    last_d  = (idx_q == c_LAST_BIN);
                    idx_d   = idx_q + 1'b1;
`ifdef HIST_INTEG_CDF_EN
                    cdf_d   = cdf_q + {{IDX_W{1'b0}}, data_d};
`endif
                    if (idx_q == c_LAST_BIN) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!valid_q || i_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            bin_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef HIST_INTEG_CDF_EN
            cdf_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            bin_q   <= bin_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef HIST_INTEG_CDF_EN
            cdf_q   <= cdf_d;
`endif
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_bin   = bin_q;
    assign o_last  = last_q;
    assign o_done  = done_q;
    assign o_busy  = (state_q != S_IDLE);
`ifdef HIST_INTEG_CDF_EN
    assign o_cdf   = cdf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_histogram_integrator.sv
// ============================================================================
// Module      : tb_histogram_integrator
// Description : Directed bench for histogram_integrator (default 256 x 16-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_histogram_integrator;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_base = '0;
    logic [15:0] i_deriv = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_ready, o_last, o_valid, o_busy, o_done;
    logic [15:0] o_data;
    logic [7:0]  o_bin;
`ifdef HIST_INTEG_CDF_EN
    logic [23:0] o_cdf;
    logic [23:0] ecdf [256];
    logic [23:0] gotc [256];
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] d    [256];
    logic [15:0] expv [256];
    logic [15:0] got  [256];

    histogram_integrator #(.BINS(256), .WIDTH(16), .IDX_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_base  (i_base),
        .i_deriv (i_deriv),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_bin   (o_bin),
        .o_last  (o_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_busy  (o_busy),
`ifdef HIST_INTEG_CDF_EN
        .o_cdf   (o_cdf),
`endif
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_data"},  {16'd0, o_data},  32'd0);
        check({tag, "_bin"},   {24'd0, o_bin},   32'd0);
        check({tag, "_last"},  {31'd0, o_last},  32'd0);
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, o_busy},  32'd0);
        check({tag, "_done"},  {31'd0, o_done},  32'd0);
`ifdef HIST_INTEG_CDF_EN
        check({tag, "_cdf"},   {8'd0, o_cdf},    32'd0);
`endif
    endtask

    // Streams one frame; rv/rr randomise i_valid/i_ready, abort_at>=0 resets
    // the block once that many beats have been accepted.
    task automatic run_frame(input logic [15:0] base, input bit rv, input bit rr,
                             input int abort_at, input bit poke_start);
        int          in_k = 0;
        int          out_k = 0;
        int          cyc = 0;
        int          last_drain = -10;
        bit          acc, drn, stall_prev, seen_done;
        logic [15:0] prev_data;
        logic [7:0]  prev_bin;
        logic        prev_last;
        stall_prev = 1'b0;
        seen_done  = 1'b0;
        expv[0] = base;
        for (int k = 1; k < 256; k++) expv[k] = expv[k-1] + d[k];
`ifdef HIST_INTEG_CDF_EN
        ecdf[0] = {8'd0, base};
        for (int k = 1; k < 256; k++) ecdf[k] = ecdf[k-1] + {8'd0, expv[k]};
`endif
        @(negedge i_clk);
        i_base  = base;
        i_start = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("busy_after_start", {31'd0, o_busy}, 32'd1);
        while (cyc < 4000) begin
            if (o_done) begin
                seen_done = 1'b1;
                break;
            end
            if (stall_prev) begin
                check("stall_data", {16'd0, o_data}, {16'd0, prev_data});
                check("stall_bin",  {24'd0, o_bin},  {24'd0, prev_bin});
                check("stall_last", {31'd0, o_last}, {31'd0, prev_last});
            end
            if (o_valid) begin
                check("data", {16'd0, o_data}, {16'd0, expv[out_k % 256]});
                check("bin",  {24'd0, o_bin},  out_k);
                check("last", {31'd0, o_last}, {31'd0, (out_k == 255)});
                got[out_k % 256] = o_data;
`ifdef HIST_INTEG_CDF_EN
                check("cdf", {8'd0, o_cdf}, {8'd0, ecdf[out_k % 256]});
                gotc[out_k % 256] = o_cdf;
`endif
            end
            if (abort_at >= 0 && in_k >= abort_at) begin
                i_rst   = 1'b1;
                i_valid = 1'b0;
                #1;
                check_idle_outputs("abort");
                repeat (3) begin
                    @(negedge i_clk);
                    check("abort_no_done", {31'd0, o_done}, 32'd0);
                    check("abort_busy",    {31'd0, o_busy}, 32'd0);
                end
                i_rst = 1'b0;
                return;
            end
            i_valid = (in_k < 256) && (rv ? ($urandom_range(0, 1) == 1) : 1'b1);
            i_deriv = d[in_k % 256];
            i_ready = rr ? ($urandom_range(0, 1) == 1) : 1'b1;
            i_start = poke_start && (in_k >= 50) && (in_k < 53);
            if (i_start) i_base = 16'h1234;
            #1;
            acc        = i_valid && o_ready;
            drn        = o_valid && i_ready;
            stall_prev = o_valid && !i_ready;
            prev_data  = o_data;
            prev_bin   = o_bin;
            prev_last  = o_last;
            @(negedge i_clk);
            cyc++;
            if (acc) in_k++;
            if (drn) begin
                out_k++;
                if (out_k == 256) last_drain = cyc;
            end
        end
        i_start = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("frame_done_seen", {31'd0, seen_done}, 32'd1);
        check("frame_in_count",  in_k,  256);
        check("frame_out_count", out_k, 256);
        check("done_latency",    cyc - last_drain, 0);
        check("idle_after_done", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        check("done_one_cycle",  {31'd0, o_done}, 32'd0);
        check("no_extra_valid",  {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        #1 i_rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        #20 i_rst = 1'b0;

        // Constant histogram: base 5, all-zero differences.
        for (int k = 0; k < 256; k++) d[k] = 16'h0000;
        run_frame(16'd5, 1'b0, 1'b0, -1, 1'b0);
        check("f1_bin0",   {16'd0, got[0]},   32'd5);
        check("f1_bin128", {16'd0, got[128]}, 32'd5);
        check("f1_bin255", {16'd0, got[255]}, 32'd5);

        // Ramp of 3 per bin; i_start pokes during RUN must be ignored.
        for (int k = 0; k < 256; k++) d[k] = (k == 0) ? 16'h0000 : 16'h0003;
        run_frame(16'd0, 1'b0, 1'b0, -1, 1'b1);
        check("f2_bin1",   {16'd0, got[1]},   32'd3);
        check("f2_bin100", {16'd0, got[100]}, 32'd300);
        check("f2_bin255", {16'd0, got[255]}, 32'd765);

        // Modular wrap around 2^16.
        for (int k = 0; k < 256; k++) d[k] = 16'h0000;
        d[0] = 16'hBEEF;
        d[1] = 16'h0001;
        d[2] = 16'hFFFF;
        run_frame(16'hFFFF, 1'b0, 1'b1, -1, 1'b0);
        check("f3_bin0", {16'd0, got[0]}, 32'h0000FFFF);
        check("f3_bin1", {16'd0, got[1]}, 32'h00000000);
        check("f3_bin2", {16'd0, got[2]}, 32'h0000FFFF);

        // Random differences under random valid/ready back-pressure.
        for (int k = 0; k < 256; k++) d[k] = 16'($urandom);
        run_frame(16'h0100, 1'b1, 1'b1, -1, 1'b0);

        // Reset after 100 accepted beats, then a clean frame.
        run_frame(16'h0042, 1'b1, 1'b1, 100, 1'b0);
        for (int k = 0; k < 256; k++) d[k] = 16'h0000;
        run_frame(16'd1, 1'b0, 1'b1, -1, 1'b0);
        check("f6_bin0",   {16'd0, got[0]},   32'd1);
        check("f6_bin255", {16'd0, got[255]}, 32'd1);
`ifdef HIST_INTEG_CDF_EN
        check("f6_cdf0",   {8'd0, gotc[0]},   32'd1);
        check("f6_cdf9",   {8'd0, gotc[9]},   32'd10);
        check("f6_cdf255", {8'd0, gotc[255]}, 32'd256);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
